// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: ALU encodings, the $0 index and the control/data
// bundles carried between stages.
package pipe_pkg;

  localparam logic [3:0] ALU_AND = 4'd0;
  localparam logic [3:0] ALU_OR  = 4'd1;
  localparam logic [3:0] ALU_ADD = 4'd2;
  localparam logic [3:0] ALU_SUB = 4'd6;
  localparam logic [3:0] ALU_SLT = 4'd7;
  localparam logic [3:0] ALU_NOR = 4'd12;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // Field order is shared by IF/ID, ID/EX and EX/MEM; RegDst is consumed at ID/EX capture.
  typedef struct packed {
    logic       RegWrite;
    logic       MemtoReg;
    logic       MemRead;
    logic       MemWrite;
    logic       ALUSrc;
    logic [3:0] ALUCtrl;
  } exCtrl_t;

  typedef struct packed {
    logic [31:0] pcplus4;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
  } exData_t;

  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] writeReg;
  } exRegs_t;

  function automatic logic [4:0] selWriteReg(input logic regDst,
                                             input logic [4:0] rd,
                                             input logic [4:0] rt);
    return regDst ? rd : rt;
  endfunction

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard check: a valid load in EX whose destination is
// read by the instruction in ID.
module load_use_detect
  import pipe_pkg::*;
(
  input  logic       memReadEx,
  input  logic       validEx,
  input  logic [4:0] writeRegEx,
  input  logic       usesRs,
  input  logic       usesRt,
  input  logic [4:0] rsId,
  input  logic [4:0] rtId,
  output logic       hazard
);

  logic rsMatch;
  logic rtMatch;

  assign rsMatch = usesRs && (rsId == writeRegEx);
  assign rtMatch = usesRt && (rtId == writeRegEx);

  // Loads into $0 are architecturally discarded, so they never need a bubble.
  assign hazard = memReadEx && validEx && (writeRegEx != REG_ZERO) && (rsMatch || rtMatch);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, kill, freeze and a
// saturating count of stall cycles.
module id_ex_stage
  import pipe_pkg::*;
#(
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   freeze,
  input  logic                   kill_id,
  input  logic [31:0]            pcplus4_id,
  input  logic [31:0]            rd1_id,
  input  logic [31:0]            rd2_id,
  input  logic [31:0]            imm_id,
  input  logic [4:0]             insrs_id,
  input  logic [4:0]             insrt_id,
  input  logic [4:0]             insrd_id,
  input  logic                   uses_rs_id,
  input  logic                   uses_rt_id,
  input  logic                   RegWrite_id,
  input  logic                   MemtoReg_id,
  input  logic                   MemRead_id,
  input  logic                   MemWrite_id,
  input  logic                   ALUSrc_id,
  input  logic                   RegDst_id,
  input  logic [3:0]             ALUCtrl_id,
  output logic                   stall,
  output logic                   valid_ex,
  output logic [31:0]            pcplus4_ex,
  output logic [31:0]            rd1_ex,
  output logic [31:0]            rd2_ex,
  output logic [31:0]            imm_ex,
  output logic [4:0]             insrs_ex,
  output logic [4:0]             insrt_ex,
  output logic [4:0]             writereg_ex,
  output logic                   RegWrite_ex,
  output logic                   MemtoReg_ex,
  output logic                   MemRead_ex,
  output logic                   MemWrite_ex,
  output logic                   ALUSrc_ex,
  output logic [3:0]             ALUCtrl_ex,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  localparam logic [STALL_CNT_W-1:0] CNT_ONE = 1;

  logic    hazard;
  logic    bubble;
  logic    validQ, validD;
  exCtrl_t ctrlQ, ctrlD;
  exData_t dataQ, dataD;
  exRegs_t regsQ, regsD;
  logic [STALL_CNT_W-1:0] cntQ;

  load_use_detect uDetect (
    .memReadEx  (ctrlQ.MemRead),
    .validEx    (validQ),
    .writeRegEx (regsQ.writeReg),
    .usesRs     (uses_rs_id),
    .usesRt     (uses_rt_id),
    .rsId       (insrs_id),
    .rtId       (insrt_id),
    .hazard     (hazard)
  );

  // Under freeze everything holds anyway, and a killed instruction needs no hold.
  assign stall  = hazard && !kill_id && !freeze;
  assign bubble = kill_id || hazard;

  always_comb begin
    validD = validQ;
    ctrlD  = ctrlQ;
    dataD  = dataQ;
    regsD  = regsQ;
    if (!freeze) begin
      if (bubble) begin
        validD = 1'b0;
        ctrlD  = '0;
        dataD  = '0;
        regsD  = '0;
      end else begin
        validD           = 1'b1;
        ctrlD.RegWrite   = RegWrite_id;
        ctrlD.MemtoReg   = MemtoReg_id;
        ctrlD.MemRead    = MemRead_id;
        ctrlD.MemWrite   = MemWrite_id;
        ctrlD.ALUSrc     = ALUSrc_id;
        ctrlD.ALUCtrl    = ALUCtrl_id;
        dataD.pcplus4    = pcplus4_id;
        dataD.rd1        = rd1_id;
        dataD.rd2        = rd2_id;
        dataD.imm        = imm_id;
        regsD.rs         = insrs_id;
        regsD.rt         = insrt_id;
        regsD.writeReg   = selWriteReg(RegDst_id, insrd_id, insrt_id);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      validQ <= 1'b0;
      ctrlQ  <= '0;
      dataQ  <= '0;
      regsQ  <= '0;
    end else begin
      validQ <= validD;
      ctrlQ  <= ctrlD;
      dataQ  <= dataD;
      regsQ  <= regsD;
    end
  end

  // Saturating: a wrapped count would understate hazard cost in long runs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cntQ <= '0;
    end else if (stall && (cntQ != '1)) begin
      cntQ <= cntQ + CNT_ONE;
    end
  end

  assign valid_ex    = validQ;
  assign pcplus4_ex  = dataQ.pcplus4;
  assign rd1_ex      = dataQ.rd1;
  assign rd2_ex      = dataQ.rd2;
  assign imm_ex      = dataQ.imm;
  assign insrs_ex    = regsQ.rs;
  assign insrt_ex    = regsQ.rt;
  assign writereg_ex = regsQ.writeReg;
  assign RegWrite_ex = ctrlQ.RegWrite;
  assign MemtoReg_ex = ctrlQ.MemtoReg;
  assign MemRead_ex  = ctrlQ.MemRead;
  assign MemWrite_ex = ctrlQ.MemWrite;
  assign ALUSrc_ex   = ctrlQ.ALUSrc;
  assign ALUCtrl_ex  = ctrlQ.ALUCtrl;
  assign stall_cnt   = cntQ;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed vector table, then random stimulus against a
// behavioural model of the EX slot; a 2-bit-counter copy covers saturation.
module tb_id_ex_stage;
  import pipe_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        freeze, kill_id;
  logic [31:0] pcplus4_id, rd1_id, rd2_id, imm_id;
  logic [4:0]  insrs_id, insrt_id, insrd_id;
  logic        uses_rs_id, uses_rt_id;
  logic        RegWrite_id, MemtoReg_id, MemRead_id, MemWrite_id, ALUSrc_id, RegDst_id;
  logic [3:0]  ALUCtrl_id;

  logic        stall, valid_ex;
  logic [31:0] pcplus4_ex, rd1_ex, rd2_ex, imm_ex;
  logic [4:0]  insrs_ex, insrt_ex, writereg_ex;
  logic        RegWrite_ex, MemtoReg_ex, MemRead_ex, MemWrite_ex, ALUSrc_ex;
  logic [3:0]  ALUCtrl_ex;
  logic [15:0] stall_cnt;

  logic        sStall, sValid;
  logic [31:0] sPc, sRd1, sRd2, sImm;
  logic [4:0]  sRs, sRt, sWr;
  logic        sRw, sM2r, sMr, sMw, sAs;
  logic [3:0]  sAlu;
  logic [1:0]  sCnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.STALL_CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .freeze(freeze), .kill_id(kill_id),
    .pcplus4_id(pcplus4_id), .rd1_id(rd1_id), .rd2_id(rd2_id), .imm_id(imm_id),
    .insrs_id(insrs_id), .insrt_id(insrt_id), .insrd_id(insrd_id),
    .uses_rs_id(uses_rs_id), .uses_rt_id(uses_rt_id),
    .RegWrite_id(RegWrite_id), .MemtoReg_id(MemtoReg_id), .MemRead_id(MemRead_id),
    .MemWrite_id(MemWrite_id), .ALUSrc_id(ALUSrc_id), .RegDst_id(RegDst_id),
    .ALUCtrl_id(ALUCtrl_id),
    .stall(stall), .valid_ex(valid_ex),
    .pcplus4_ex(pcplus4_ex), .rd1_ex(rd1_ex), .rd2_ex(rd2_ex), .imm_ex(imm_ex),
    .insrs_ex(insrs_ex), .insrt_ex(insrt_ex), .writereg_ex(writereg_ex),
    .RegWrite_ex(RegWrite_ex), .MemtoReg_ex(MemtoReg_ex), .MemRead_ex(MemRead_ex),
    .MemWrite_ex(MemWrite_ex), .ALUSrc_ex(ALUSrc_ex), .ALUCtrl_ex(ALUCtrl_ex),
    .stall_cnt(stall_cnt)
  );

  id_ex_stage #(.STALL_CNT_W(2)) dutSat (
    .clk(clk), .rst_n(rst_n), .freeze(freeze), .kill_id(kill_id),
    .pcplus4_id(pcplus4_id), .rd1_id(rd1_id), .rd2_id(rd2_id), .imm_id(imm_id),
    .insrs_id(insrs_id), .insrt_id(insrt_id), .insrd_id(insrd_id),
    .uses_rs_id(uses_rs_id), .uses_rt_id(uses_rt_id),
    .RegWrite_id(RegWrite_id), .MemtoReg_id(MemtoReg_id), .MemRead_id(MemRead_id),
    .MemWrite_id(MemWrite_id), .ALUSrc_id(ALUSrc_id), .RegDst_id(RegDst_id),
    .ALUCtrl_id(ALUCtrl_id),
    .stall(sStall), .valid_ex(sValid),
    .pcplus4_ex(sPc), .rd1_ex(sRd1), .rd2_ex(sRd2), .imm_ex(sImm),
    .insrs_ex(sRs), .insrt_ex(sRt), .writereg_ex(sWr),
    .RegWrite_ex(sRw), .MemtoReg_ex(sM2r), .MemRead_ex(sMr),
    .MemWrite_ex(sMw), .ALUSrc_ex(sAs), .ALUCtrl_ex(sAlu),
    .stall_cnt(sCnt)
  );

  // Reference model: contents of the EX slot plus the two stall tallies.
  typedef struct {
    bit          valid;
    logic [31:0] pc, rd1, rd2, imm;
    logic [4:0]  rs, rt, wr;
    bit          rw, m2r, mr, mw, as;
    logic [3:0]  alu;
  } slot_t;

  slot_t m;
  int    mCnt, mCnt2;

  function automatic slot_t emptySlot();
    slot_t s;
    s.valid = 0; s.pc = 0; s.rd1 = 0; s.rd2 = 0; s.imm = 0;
    s.rs = 0; s.rt = 0; s.wr = 0;
    s.rw = 0; s.m2r = 0; s.mr = 0; s.mw = 0; s.as = 0; s.alu = 0;
    return s;
  endfunction

  function automatic bit modelHazard();
    bit dep;
    dep = (uses_rs_id && insrs_id == m.wr) || (uses_rt_id && insrt_id == m.wr);
    return m.valid && m.mr && (m.wr != 0) && dep;
  endfunction

  function automatic bit modelStall();
    return modelHazard() && !kill_id && !freeze;
  endfunction

  task automatic modelReset();
    m = emptySlot();
    mCnt = 0;
    mCnt2 = 0;
  endtask

  task automatic modelEdge();
    bit st;
    st = modelStall();
    if (freeze) return;
    if (st) begin
      if (mCnt < 65535) mCnt++;
      if (mCnt2 < 3) mCnt2++;
    end
    if (kill_id || modelHazard()) begin
      m = emptySlot();
    end else begin
      m.valid = 1; m.pc = pcplus4_id; m.rd1 = rd1_id; m.rd2 = rd2_id; m.imm = imm_id;
      m.rs = insrs_id; m.rt = insrt_id; m.wr = RegDst_id ? insrd_id : insrt_id;
      m.rw = RegWrite_id; m.m2r = MemtoReg_id; m.mr = MemRead_id; m.mw = MemWrite_id;
      m.as = ALUSrc_id; m.alu = ALUCtrl_id;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chkSet(input string tag, input logic st, input logic v,
                        input logic [31:0] pc, input logic [31:0] r1, input logic [31:0] r2,
                        input logic [31:0] im, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] wr, input logic rw, input logic m2r, input logic mr,
                        input logic mw, input logic as, input logic [3:0] alu,
                        input logic [31:0] cnt, input int expCnt);
    chk({tag, ".stall"}, {31'd0, st}, {31'd0, modelStall()});
    chk({tag, ".valid"}, {31'd0, v}, {31'd0, m.valid});
    chk({tag, ".pc"}, pc, m.pc);
    chk({tag, ".rd1"}, r1, m.rd1);
    chk({tag, ".rd2"}, r2, m.rd2);
    chk({tag, ".imm"}, im, m.imm);
    chk({tag, ".regs"}, {17'd0, rs, rt, wr}, {17'd0, m.rs, m.rt, m.wr});
    chk({tag, ".ctrl"}, {23'd0, rw, m2r, mr, mw, as, alu},
        {23'd0, m.rw, m.m2r, m.mr, m.mw, m.as, m.alu});
    chk({tag, ".cnt"}, cnt, expCnt);
  endtask

  task automatic checkModel();
    chkSet("main", stall, valid_ex, pcplus4_ex, rd1_ex, rd2_ex, imm_ex, insrs_ex, insrt_ex,
           writereg_ex, RegWrite_ex, MemtoReg_ex, MemRead_ex, MemWrite_ex, ALUSrc_ex,
           ALUCtrl_ex, {16'd0, stall_cnt}, mCnt);
    chkSet("sat", sStall, sValid, sPc, sRd1, sRd2, sImm, sRs, sRt, sWr, sRw, sM2r, sMr,
           sMw, sAs, sAlu, {30'd0, sCnt}, mCnt2);
  endtask

  task automatic randData();
    pcplus4_id = $urandom; rd1_id = $urandom; rd2_id = $urandom; imm_id = $urandom;
  endtask

  task automatic randAll();
    randData();
    freeze      = ($urandom_range(0, 9) == 0);
    kill_id     = ($urandom_range(0, 9) == 0);
    insrs_id    = 5'($urandom_range(0, 3));
    insrt_id    = 5'($urandom_range(0, 3));
    insrd_id    = 5'($urandom_range(0, 3));
    uses_rs_id  = 1'($urandom);
    uses_rt_id  = 1'($urandom);
    RegWrite_id = 1'($urandom);
    MemtoReg_id = 1'($urandom);
    MemRead_id  = ($urandom_range(0, 2) == 0);
    MemWrite_id = 1'($urandom);
    ALUSrc_id   = 1'($urandom);
    RegDst_id   = 1'($urandom);
    ALUCtrl_id  = 4'($urandom);
  endtask

  // One clock: outputs and stall checked at the falling edge, model advanced at the rising edge.
  task automatic cycle();
    @(negedge clk);
    checkModel();
    @(posedge clk);
    modelEdge();
    #1;
  endtask

  typedef struct {
    bit fz, kl, mr, rw, rdst, urs, urt;
    logic [4:0] rs, rt, rd;
    bit eStall, eValid, eRw, eMr;
    logic [4:0] eWr;
    int eCnt, eCnt2;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(bit fz, bit kl, bit mr, bit rw, bit rdst,
                              int rs, int rt, int rd, bit urs, bit urt,
                              bit eStall, bit eValid, int eWr, bit eRw, bit eMr,
                              int eCnt, int eCnt2);
    vec_t v;
    v.fz = fz; v.kl = kl; v.mr = mr; v.rw = rw; v.rdst = rdst;
    v.rs = 5'(rs); v.rt = 5'(rt); v.rd = 5'(rd); v.urs = urs; v.urt = urt;
    v.eStall = eStall; v.eValid = eValid; v.eWr = 5'(eWr); v.eRw = eRw; v.eMr = eMr;
    v.eCnt = eCnt; v.eCnt2 = eCnt2;
    return v;
  endfunction

  initial begin
    //           fz kl mr rw rd  rs  rt  rd us ut | stl val wr rw mr cnt cnt2
    vecs.push_back(mk(0, 0, 0, 1, 1,  1,  2,  8, 1, 1,  0, 1,  8, 1, 0, 0, 0)); // add $8
    vecs.push_back(mk(0, 0, 1, 1, 0,  3,  9,  0, 1, 0,  0, 1,  9, 1, 1, 0, 0)); // lw $9
    vecs.push_back(mk(0, 0, 0, 1, 1,  9,  4, 10, 1, 1,  1, 0,  0, 0, 0, 1, 1)); // add uses $9: bubble
    vecs.push_back(mk(0, 0, 0, 1, 1,  9,  4, 10, 1, 1,  0, 1, 10, 1, 0, 1, 1)); // add captures
    vecs.push_back(mk(0, 0, 1, 1, 0,  5,  0,  0, 1, 0,  0, 1,  0, 1, 1, 1, 1)); // lw $0
    vecs.push_back(mk(0, 0, 0, 1, 1,  0,  0, 11, 1, 1,  0, 1, 11, 1, 0, 1, 1)); // use $0: no stall
    vecs.push_back(mk(0, 0, 1, 1, 0,  1,  9,  0, 1, 0,  0, 1,  9, 1, 1, 1, 1)); // lw $9
    vecs.push_back(mk(0, 0, 0, 1, 1,  2,  9, 12, 1, 0,  0, 1, 12, 1, 0, 1, 1)); // rt=9 unused
    vecs.push_back(mk(0, 0, 1, 1, 0,  1,  9,  0, 1, 0,  0, 1,  9, 1, 1, 1, 1)); // lw $9
    vecs.push_back(mk(0, 1, 0, 1, 1,  9,  4, 10, 1, 1,  0, 0,  0, 0, 0, 1, 1)); // kill during hazard
    vecs.push_back(mk(0, 0, 1, 1, 0,  1, 13,  0, 1, 0,  0, 1, 13, 1, 1, 1, 1)); // lw $13
    vecs.push_back(mk(1, 0, 0, 1, 1,  2, 13, 14, 1, 1,  0, 1, 13, 1, 1, 1, 1)); // freeze x3
    vecs.push_back(mk(1, 0, 0, 1, 1,  2, 13, 14, 1, 1,  0, 1, 13, 1, 1, 1, 1));
    vecs.push_back(mk(1, 0, 0, 1, 1,  2, 13, 14, 1, 1,  0, 1, 13, 1, 1, 1, 1));
    vecs.push_back(mk(0, 0, 0, 1, 1,  2, 13, 14, 1, 1,  1, 0,  0, 0, 0, 2, 2)); // bubble after release
    vecs.push_back(mk(0, 0, 0, 1, 1,  2, 13, 14, 1, 1,  0, 1, 14, 1, 0, 2, 2));
    vecs.push_back(mk(0, 0, 1, 1, 0,  1, 15,  0, 1, 0,  0, 1, 15, 1, 1, 2, 2)); // lw $15
    vecs.push_back(mk(0, 0, 1, 1, 0, 15, 16,  0, 1, 0,  1, 0,  0, 0, 0, 3, 3)); // lw $16 <- $15
    vecs.push_back(mk(0, 0, 1, 1, 0, 15, 16,  0, 1, 0,  0, 1, 16, 1, 1, 3, 3));
    vecs.push_back(mk(0, 0, 1, 1, 0, 16, 17,  0, 1, 0,  1, 0,  0, 0, 0, 4, 3)); // lw $17 <- $16
    vecs.push_back(mk(0, 0, 1, 1, 0, 16, 17,  0, 1, 0,  0, 1, 17, 1, 1, 4, 3));
    vecs.push_back(mk(0, 0, 0, 1, 1, 17, 17, 18, 1, 1,  1, 0,  0, 0, 0, 5, 3)); // add <- $17
    vecs.push_back(mk(0, 0, 0, 1, 1, 17, 17, 18, 1, 1,  0, 1, 18, 1, 0, 5, 3));

    rst_n = 1'b0;
    modelReset();
    randAll();
    #1;
    for (int i = 0; i < 3; i++) begin
      randAll();
      cycle();
      modelReset();
    end
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      randData();
      freeze = vecs[i].fz; kill_id = vecs[i].kl;
      MemRead_id = vecs[i].mr; MemtoReg_id = vecs[i].mr; ALUSrc_id = vecs[i].mr;
      RegWrite_id = vecs[i].rw; RegDst_id = vecs[i].rdst; MemWrite_id = 1'b0;
      ALUCtrl_id = ALU_ADD;
      insrs_id = vecs[i].rs; insrt_id = vecs[i].rt; insrd_id = vecs[i].rd;
      uses_rs_id = vecs[i].urs; uses_rt_id = vecs[i].urt;
      @(negedge clk);
      chk($sformatf("vec%0d.stall", i), {31'd0, stall}, {31'd0, vecs[i].eStall});
      checkModel();
      @(posedge clk);
      modelEdge();
      #1;
      chk($sformatf("vec%0d.valid", i), {31'd0, valid_ex}, {31'd0, vecs[i].eValid});
      chk($sformatf("vec%0d.wr", i), {27'd0, writereg_ex}, {27'd0, vecs[i].eWr});
      chk($sformatf("vec%0d.rw_mr", i), {30'd0, RegWrite_ex, MemRead_ex},
          {30'd0, vecs[i].eRw, vecs[i].eMr});
      chk($sformatf("vec%0d.cnt", i), {16'd0, stall_cnt}, vecs[i].eCnt);
      chk($sformatf("vec%0d.cnt2", i), {30'd0, sCnt}, vecs[i].eCnt2);
    end

    for (int i = 0; i < 1500; i++) begin
      randAll();
      cycle();
    end

    // Asynchronous reset mid-program, then restart from an empty pipe.
    #2;
    rst_n = 1'b0;
    #1;
    modelReset();
    checkModel();
    for (int i = 0; i < 2; i++) begin
      randAll();
      cycle();
      modelReset();
    end
    rst_n = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      randAll();
      cycle();
    end

    @(negedge clk);
    checkModel();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register for the 5-stage MIPS pipeline, with integrated load-use hazard detection.
- Captures decoded operands, register indices and control from ID and presents them to EX.
- Its EX-side rs/rt indices drive the operand-forwarding unit; its `writereg_ex` and control drive the EX/MEM register.
- Inserts a bubble on load-use hazards or kills, and holds the whole pipe on an external freeze.

Parameters:
- STALL_CNT_W, 16, width of the saturating load-use stall-cycle counter.

Ports:
- clk  in  1  pipeline clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- freeze  in  1  global pipeline hold (e.g. memory wait); highest priority
- kill_id  in  1  discard the instruction currently in ID (exception/redirect)
- pcplus4_id  in  32  PC+4 of ID instruction
- rd1_id  in  32  register-file read data, rs
- rd2_id  in  32  register-file read data, rt
- imm_id  in  32  sign/zero-extended immediate
- insrs_id  in  5  rs field
- insrt_id  in  5  rt field
- insrd_id  in  5  rd field
- uses_rs_id  in  1  instruction reads rs
- uses_rt_id  in  1  instruction reads rt
- RegWrite_id, MemtoReg_id, MemRead_id, MemWrite_id, ALUSrc_id, RegDst_id  in  1 each  decoded control
- ALUCtrl_id  in  4  ALU operation
- stall  out  1  hold PC and IF/ID this cycle (combinational)
- valid_ex  out  1  EX slot holds a real instruction
- pcplus4_ex, rd1_ex, rd2_ex, imm_ex  out  32 each  registered copies
- insrs_ex, insrt_ex  out  5 each  to forwarding unit
- writereg_ex  out  5  destination: RegDst ? rd : rt, resolved at capture
- RegWrite_ex, MemtoReg_ex, MemRead_ex, MemWrite_ex, ALUSrc_ex  out  1 each
- ALUCtrl_ex  out  4
- stall_cnt  out  STALL_CNT_W  number of cycles in which stall was asserted

Behaviour:
- Reset, asynchronous on rst_n low: every registered output goes to 0, including `valid_ex` and `stall_cnt`. Therefore `stall` = 0.
- Hazard detection (combinational):
  - hazard = MemRead_ex & valid_ex & (writereg_ex != 0) & ((uses_rs_id & insrs_id == writereg_ex) | (uses_rt_id & insrt_id == writereg_ex)).
- stall = hazard & ~kill_id & ~freeze. A killed ID instruction needs no stall; during freeze, stall is reported as 0 because everything holds anyway.
- Per rising edge, in priority order:
  1. freeze = 1: all registers hold, `stall_cnt` holds.
  2. kill_id = 1 or hazard = 1: bubble. `valid_ex` = 0; RegWrite, MemtoReg, MemRead, MemWrite and ALUSrc go to 0; ALUCtrl = 0; writereg, insrs and insrt = 0; data fields = 0.
  3. Otherwise: capture all ID inputs. `valid_ex` = 1; `writereg_ex` = RegDst_id ? insrd_id : insrt_id.
- Latency: one cycle ID→EX.
- Load-use costs exactly one bubble. After the bubble, MemRead_ex = 0, so the hazard clears and the dependent instruction captures on the next edge.
- Back-to-back loads each feeding the next: one bubble per pair.
- Writes to $0: writereg_ex = 0 never causes a stall, even for a load.
- stall_cnt increments by 1 on each edge where stall = 1. It saturates at all-ones and does not wrap.
- Reset deassertion mid-program: the pipe restarts empty. No spurious stall on the first cycle.
- Bubble slots present RegWrite_ex = 0 and writereg_ex = 0, so the forwarding unit never matches them.

Decomposition:
- Shared package `pipe_pkg`:
  - ALUCtrl encodings (4-bit localparams).
  - REG_ZERO = 5'd0.
  - Control-bundle field order, used consistently by IF/ID, ID/EX and EX/MEM.
- Sub-module `load_use_detect`: purely combinational hazard equation, reusable by a future ID-stage branch-hazard check. The register bank stays in `id_ex_stage`.

Test Plan:
- Reset: hold rst_n = 0 with random inputs → all outputs 0, stall = 0. Release → first edge captures `add` (RegDst = 1, rd = 8) → writereg_ex = 8, valid_ex = 1.
- Load-use: `lw $9` in EX, then `add` with rs = 9, uses_rs = 1 in ID → stall = 1 for exactly one cycle, then a bubble with RegWrite_ex = 0. The next edge captures the `add`; stall_cnt = 1.
- No false stall: `lw $0` followed by a use of rs = 0 → stall = 0. `lw $9` followed by an instruction with rt = 9 and uses_rt = 0 → stall = 0.
- Kill during hazard: the load-use condition holds and kill_id = 1 in the same cycle → stall = 0, bubble inserted, stall_cnt unchanged.
- Freeze: assert freeze for 3 cycles while a load-use condition holds → all EX outputs are constant, stall = 0, stall_cnt constant. After release, the one-bubble sequence proceeds normally.
- Counter saturation: with STALL_CNT_W = 2, force 5 stall cycles → stall_cnt reads 1, 2, 3, 3, 3.
